translation_multi: RTL

//  Parametrised multi-channel address-translation model for the AXI MMU testbench, successor to the

---
 rtl/xlate_pkg.sv | 20 ++
 rtl/xlate_channel.sv | 150 +++++++++++++++
 rtl/translation_multi.sv | 63 ++++++
 3 files changed

// File: rtl/xlate_pkg.sv
// Shared types and constants for the multi-channel address translator.
package xlate_pkg;

   localparam int unsigned LEN_W      = 8;
   localparam int unsigned SIZE_W     = 3;
   localparam int unsigned PAGE_SHIFT = 12;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StResp
   } xlate_state_e;

   // Burst attributes; the address field is sized per instance in xlate_channel.
   typedef struct packed {
      logic [LEN_W-1:0]  len;
      logic [SIZE_W-1:0] size;
   } xlate_attr_t;

endpackage

// File: rtl/xlate_channel.sv
// One translation channel: request queue, fixed-latency FSM, offset/limit registers.
module xlate_channel
   import xlate_pkg::*;
#(
   parameter int unsigned     AW         = 32,
   parameter int unsigned     QDEPTH     = 4,
   parameter int unsigned     LATENCY    = 40,
   parameter logic [AW-1:0]   RST_OFFSET = '0,
   parameter logic [AW-1:0]   RST_LIMIT  = '1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [AW-1:0]     req_vaddr_i,
   input  logic [LEN_W-1:0]  req_len_i,
   input  logic [SIZE_W-1:0] req_size_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [AW-1:0]     rsp_paddr_o,
   output logic              rsp_err_o,
   input  logic              cfg_we_i,
   input  logic [AW-1:0]     cfg_offset_i,
   input  logic [AW-1:0]     cfg_limit_i
);

   localparam int unsigned PtrW = $clog2(QDEPTH);
   localparam int unsigned CntW = $clog2(LATENCY);
   localparam logic [PtrW:0]   Full = (PtrW + 1)'(QDEPTH);
   localparam logic [CntW-1:0] Load = CntW'(LATENCY - 2);

   typedef struct packed {
      logic [AW-1:0] vaddr;
      xlate_attr_t   attr;
   } req_t;

   req_t            fifo_q [QDEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]   count_q;
   xlate_state_e    state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   req_t            cur_q;
   logic [AW-1:0]   offset_q, limit_q, snap_off_q, snap_lim_q;
   logic            rsp_valid_q, rsp_err_q;
   logic [AW-1:0]   rsp_paddr_q;

   logic            push, pop, load_rsp, drop_rsp, fault;
   logic [15:0]     nbytes;
   logic [AW:0]     end_addr;

   assign push = req_valid_i & req_ready_o;

   // Fault if below limit fails or the last byte lands in a different 4 KB page.
   always_comb begin
      nbytes   = (16'(cur_q.attr.len) + 16'd1) << cur_q.attr.size;
      end_addr = {1'b0, cur_q.vaddr} + (AW + 1)'(nbytes) - (AW + 1)'(1);
      fault    = (cur_q.vaddr >= snap_lim_q) |
                 ((end_addr >> PAGE_SHIFT) != ({1'b0, cur_q.vaddr} >> PAGE_SHIFT));
   end

   always_ff @(posedge clk_i) begin
      if (push) fifo_q[wr_ptr_q] <= '{vaddr: req_vaddr_i, attr: '{len: req_len_i, size: req_size_i}};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         cur_q       <= '0;
         offset_q    <= RST_OFFSET;
         limit_q     <= RST_LIMIT;
         snap_off_q  <= '0;
         snap_lim_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_paddr_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         count_q <= count_q + (PtrW + 1)'(push) - (PtrW + 1)'(pop);
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop) begin
            rd_ptr_q   <= rd_ptr_q + 1'b1;
            cur_q      <= fifo_q[rd_ptr_q];
            snap_off_q <= offset_q;
            snap_lim_q <= limit_q;
         end
         if (cfg_we_i) begin
            offset_q <= cfg_offset_i;
            limit_q  <= cfg_limit_i;
         end
         if (load_rsp) begin
            rsp_valid_q <= 1'b1;
            rsp_paddr_q <= cur_q.vaddr + snap_off_q;
            rsp_err_q   <= fault;
         end else if (drop_rsp) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pop      = 1'b0;
      load_rsp = 1'b0;
      drop_rsp = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               cnt_d   = Load;
               state_d = StWait;
            end
         end
         StWait: begin
            if (cnt_q == '0) begin
               load_rsp = 1'b1;
               state_d  = StResp;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StResp: begin
            if (rsp_ready_i) begin
               drop_rsp = 1'b1;
               if (count_q != '0) begin
                  pop     = 1'b1;
                  cnt_d   = Load;
                  state_d = StWait;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      req_ready_o = (count_q != Full);
      rsp_valid_o = rsp_valid_q;
      rsp_paddr_o = rsp_paddr_q;
      rsp_err_o   = rsp_err_q;
   end

endmodule

// File: rtl/translation_multi.sv
// Multi-channel address translator: slices the flat port vectors and decodes the config target.
module translation_multi
   import xlate_pkg::*;
#(
   parameter int unsigned   NUM_CH        = 2,
   parameter int unsigned   AW            = 32,
   parameter int unsigned   QDEPTH        = 4,
   parameter int unsigned   LATENCY       = 40,
   parameter logic [AW-1:0] DEF_OFFSET    = 'h1000,
   parameter logic [AW-1:0] OFFSET_STRIDE = 'h100,
   parameter logic [AW-1:0] DEF_LIMIT     = '1
) (
   input  logic                                           clk,
   input  logic                                           reset,
   input  logic [NUM_CH-1:0]                              req_valid,
   output logic [NUM_CH-1:0]                              req_ready,
   input  logic [NUM_CH*AW-1:0]                           req_vaddr,
   input  logic [NUM_CH*8-1:0]                            req_len,
   input  logic [NUM_CH*3-1:0]                            req_size,
   output logic [NUM_CH-1:0]                              rsp_valid,
   input  logic [NUM_CH-1:0]                              rsp_ready,
   output logic [NUM_CH*AW-1:0]                           rsp_paddr,
   output logic [NUM_CH-1:0]                              rsp_err,
   input  logic                                           cfg_we,
   input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
   input  logic [AW-1:0]                                  cfg_offset,
   input  logic [AW-1:0]                                  cfg_limit
);

   localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      localparam logic [AW-1:0] ChOffset = DEF_OFFSET + AW'(g) * OFFSET_STRIDE;

      // Out-of-range cfg_ch matches no channel and is dropped.
      logic ch_we;
      assign ch_we = cfg_we & (cfg_ch == CHW'(g));

      xlate_channel #(
         .AW         (AW),
         .QDEPTH     (QDEPTH),
         .LATENCY    (LATENCY),
         .RST_OFFSET (ChOffset),
         .RST_LIMIT  (DEF_LIMIT)
      ) u_ch (
         .clk_i        (clk),
         .rst_i        (reset),
         .req_valid_i  (req_valid[g]),
         .req_ready_o  (req_ready[g]),
         .req_vaddr_i  (req_vaddr[g*AW +: AW]),
         .req_len_i    (req_len[g*LEN_W +: LEN_W]),
         .req_size_i   (req_size[g*SIZE_W +: SIZE_W]),
         .rsp_valid_o  (rsp_valid[g]),
         .rsp_ready_i  (rsp_ready[g]),
         .rsp_paddr_o  (rsp_paddr[g*AW +: AW]),
         .rsp_err_o    (rsp_err[g]),
         .cfg_we_i     (ch_we),
         .cfg_offset_i (cfg_offset),
         .cfg_limit_i  (cfg_limit)
      );
   end

endmodule
